// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: pipeline hazard inputs, data-memory handshake,
// stall/flush/forward controls and status, shared between the pipeline
// (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int RAW  = 5,
    parameter int CNTW = 16
);
    // Register addresses in decode, execute, memory and writeback
    logic [RAW-1:0]  rs1D;
    logic [RAW-1:0]  rs2D;
    logic [RAW-1:0]  rs1E;
    logic [RAW-1:0]  rs2E;
    logic [RAW-1:0]  rdE;
    logic [RAW-1:0]  rdM;
    logic [RAW-1:0]  rdW;

    // Pipeline qualifiers and data-memory handshake
    logic            loadE;
    logic            pcSrcE;
    logic            regWriteM;
    logic            regWriteW;
    logic            dmem_req;
    logic            dmem_ack;

    // Controls back to the pipeline
    logic            stallF;
    logic            stallD;
    logic            stallE;
    logic            stallM;
    logic            flushD;
    logic            flushE;
    logic            flushW;
    logic [1:0]      forwardAE;
    logic [1:0]      forwardBE;

    // Status
    logic            mem_err;
    logic [CNTW-1:0] stall_cycles;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output loadE, pcSrcE, regWriteM, regWriteW, dmem_req, dmem_ack,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        input  forwardAE, forwardBE, mem_err, stall_cycles
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  loadE, pcSrcE, regWriteM, regWriteW, dmem_req, dmem_ack,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        output forwardAE, forwardBE, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding into E,
// load-use and branch hazard resolution, and a data-memory wait FSM with
// a timeout that parks the pipeline in a sticky error state. Also keeps a
// saturating count of fetch-stall cycles.
module hazard_ctrl #(
    parameter int RAW  = 5,
    parameter int CNTW = 16,
    parameter int TMO  = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    localparam logic [CNTW-1:0] TMO_C   = CNTW'(TMO);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [RAW-1:0]  REG_X0  = {RAW{1'b0}};

    state_e          state_q;
    state_e          state_d;
    logic [CNTW-1:0] wait_cnt_q;
    logic [CNTW-1:0] wait_cnt_d;
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;

    logic            lw_stall_s;
    logic            stall_f_s;
    logic            stall_d_s;
    logic            stall_e_s;
    logic            stall_m_s;
    logic            flush_d_s;
    logic            flush_e_s;
    logic            flush_w_s;
    logic [1:0]      fwd_a_s;
    logic [1:0]      fwd_b_s;

    // Operand select for one E source: M result beats W result (M is younger);
    // register x0 is never forwarded since it always reads as zero.
    function automatic logic [1:0] fwd_sel(
        input logic [RAW-1:0] rs,
        input logic [RAW-1:0] rd_m,
        input logic           we_m,
        input logic [RAW-1:0] rd_w,
        input logic           we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != REG_X0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != REG_X0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding muxes for both E operands
    always_comb begin
        fwd_a_s = fwd_sel(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
        fwd_b_s = fwd_sel(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
    end

    // Load-use hazard: a load in E whose destination a decode source needs
    always_comb begin
        lw_stall_s = hz.loadE && (hz.rdE != REG_X0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    end

    // Next-state, wait counter and stall/flush decode. A memory stall freezes
    // F..M and bubbles W; branch/load-use terms are only acted on in RUN, so
    // they are naturally re-evaluated in the first RUN cycle after an ack.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_f_s  = 1'b0;
        stall_d_s  = 1'b0;
        stall_e_s  = 1'b0;
        stall_m_s  = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        flush_w_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.dmem_req && !hz.dmem_ack) begin
                    stall_f_s  = 1'b1;
                    stall_d_s  = 1'b1;
                    stall_e_s  = 1'b1;
                    stall_m_s  = 1'b1;
                    flush_w_s  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end else if (hz.pcSrcE) begin
                    flush_d_s  = 1'b1;
                    flush_e_s  = 1'b1;
                end else if (lw_stall_s) begin
                    stall_f_s  = 1'b1;
                    stall_d_s  = 1'b1;
                    flush_e_s  = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                stall_e_s = 1'b1;
                stall_m_s = 1'b1;
                flush_w_s = 1'b1;
                if (hz.dmem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = CNT_ZERO;
                end else if (wait_cnt_q == TMO_C) begin
                    state_d    = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            ST_ERR: begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                stall_e_s = 1'b1;
                stall_m_s = 1'b1;
                flush_w_s = 1'b1;
                state_d   = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // Saturating count of cycles in which fetch is held
    always_comb begin
        if (stall_f_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Control state, wait counter and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= CNT_ZERO;
            stall_cnt_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Drive the interface; the error flag is a pure decode of the ERR state
    always_comb begin
        hz.stallF       = stall_f_s;
        hz.stallD       = stall_d_s;
        hz.stallE       = stall_e_s;
        hz.stallM       = stall_m_s;
        hz.flushD       = flush_d_s;
        hz.flushE       = flush_e_s;
        hz.flushW       = flush_w_s;
        hz.forwardAE    = fwd_a_s;
        hz.forwardBE    = fwd_b_s;
        hz.mem_err      = (state_q == ST_ERR);
        hz.stall_cycles = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with CNTW=4 and TMO=3 so that timeout and
// counter saturation are reachable in a few dozen cycles.
// Control vector order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}.
module tb_hazard_ctrl;

    localparam int RAW  = 5;
    localparam int CNTW = 4;
    localparam int TMO  = 3;

    localparam logic [6:0] CTL_NONE = 7'b0000000;
    localparam logic [6:0] CTL_LW   = 7'b1100010;
    localparam logic [6:0] CTL_BR   = 7'b0000110;
    localparam logic [6:0] CTL_MEM  = 7'b1111001;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [6:0] ctl_s;

    hazard_ctrl_if #(.RAW(RAW), .CNTW(CNTW)) hif ();

    hazard_ctrl #(.RAW(RAW), .CNTW(CNTW), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    assign ctl_s = {hif.stallF, hif.stallD, hif.stallE, hif.stallM,
                    hif.flushD, hif.flushE, hif.flushW};

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        hif.rs1D = 5'd0; hif.rs2D = 5'd0;
        hif.rs1E = 5'd0; hif.rs2E = 5'd0; hif.rdE = 5'd0;
        hif.rdM = 5'd0;  hif.rdW = 5'd0;
        hif.loadE = 1'b0; hif.pcSrcE = 1'b0;
        hif.regWriteM = 1'b0; hif.regWriteW = 1'b0;
        hif.dmem_req = 1'b0; hif.dmem_ack = 1'b0;
    endtask

    task automatic set_lw();
        hif.loadE = 1'b1; hif.rdE = 5'd5; hif.rs1D = 5'd5; hif.rs2D = 5'd7;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        set_idle();
        #2;
        check_eq("rst_ctl", 32'(ctl_s), 32'(CTL_NONE));
        check_eq("rst_sc", 32'(hif.stall_cycles), 32'd0);
        check_eq("rst_err", 32'(hif.mem_err), 32'd0);
        #10;
        rst_n = 1'b1;

        // Forwarding: M beats W, x0 never forwarded
        hif.regWriteM = 1'b1; hif.rdM = 5'd3;
        hif.regWriteW = 1'b1; hif.rdW = 5'd3;
        hif.rs1E = 5'd3; hif.rs2E = 5'd4;
        #1;
        check_eq("fwdA_M", 32'(hif.forwardAE), 32'd2);
        check_eq("fwdB_none", 32'(hif.forwardBE), 32'd0);
        hif.rdM = 5'd0;
        #1;
        check_eq("fwdA_W", 32'(hif.forwardAE), 32'd1);
        hif.rs2E = 5'd3;
        #1;
        check_eq("fwdB_W", 32'(hif.forwardBE), 32'd1);
        hif.regWriteW = 1'b0;
        #1;
        check_eq("fwdA_wedis", 32'(hif.forwardAE), 32'd0);
        hif.regWriteM = 1'b1; hif.rdM = 5'd0; hif.rs1E = 5'd0;
        hif.regWriteW = 1'b1; hif.rdW = 5'd0;
        #1;
        check_eq("fwdA_x0", 32'(hif.forwardAE), 32'd0);
        set_idle();

        // Load-use stall
        set_lw();
        #1;
        check_eq("lw_ctl", 32'(ctl_s), 32'(CTL_LW));
        tick();
        check_eq("lw_sc", 32'(hif.stall_cycles), 32'd1);
        hif.rs1D = 5'd0; hif.rs2D = 5'd5;
        #1;
        check_eq("lw_rs2", 32'(ctl_s), 32'(CTL_LW));
        hif.rdE = 5'd0; hif.rs2D = 5'd0;
        #1;
        check_eq("lw_x0", 32'(ctl_s), 32'(CTL_NONE));

        // Branch beats load-use
        set_lw(); hif.pcSrcE = 1'b1;
        #1;
        check_eq("br_prio", 32'(ctl_s), 32'(CTL_BR));
        tick();
        check_eq("br_sc", 32'(hif.stall_cycles), 32'd1);
        set_idle();

        // Request acknowledged in the same cycle: no stall
        hif.dmem_req = 1'b1; hif.dmem_ack = 1'b1;
        #1;
        check_eq("reqack_ctl", 32'(ctl_s), 32'(CTL_NONE));
        tick();
        hif.dmem_req = 1'b0; hif.dmem_ack = 1'b0;
        #1;
        check_eq("reqack_run", 32'(ctl_s), 32'(CTL_NONE));

        // Memory wait, ack on 4th cycle (counter already at TMO: ack wins)
        set_lw(); hif.pcSrcE = 1'b1;
        hif.dmem_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) hif.dmem_ack = 1'b1;
            #1;
            check_eq($sformatf("mw_ctl%0d", c), 32'(ctl_s), 32'(CTL_MEM));
            tick();
        end
        hif.dmem_req = 1'b0; hif.dmem_ack = 1'b0;
        #1;
        check_eq("mw_br_after", 32'(ctl_s), 32'(CTL_BR));
        check_eq("mw_sc", 32'(hif.stall_cycles), 32'd5);
        check_eq("mw_noerr", 32'(hif.mem_err), 32'd0);
        hif.pcSrcE = 1'b0;
        #1;
        check_eq("mw_lw_after", 32'(ctl_s), 32'(CTL_LW));
        tick();
        set_idle();

        // Asynchronous reset mid-cycle clears the counter
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sc", 32'(hif.stall_cycles), 32'd0);
        #2;
        rst_n = 1'b1;

        // Timeout into ERR, then saturation of the stall counter
        hif.dmem_req = 1'b1;
        #1;
        check_eq("to_ctl1", 32'(ctl_s), 32'(CTL_MEM));
        tick();
        check_eq("to_err1", 32'(hif.mem_err), 32'd0);
        tick();
        tick();
        check_eq("to_err3", 32'(hif.mem_err), 32'd0);
        tick();
        check_eq("to_err4", 32'(hif.mem_err), 32'd1);
        check_eq("to_sc4", 32'(hif.stall_cycles), 32'd4);
        hif.dmem_req = 1'b0;
        #1;
        check_eq("err_ctl", 32'(ctl_s), 32'(CTL_MEM));
        repeat (16) tick();
        check_eq("sat_sc", 32'(hif.stall_cycles), 32'd15);
        check_eq("err_sticky", 32'(hif.mem_err), 32'd1);

        // Reset out of ERR, then behave as RUN
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("err_rst_err", 32'(hif.mem_err), 32'd0);
        check_eq("err_rst_sc", 32'(hif.stall_cycles), 32'd0);
        check_eq("err_rst_ctl", 32'(ctl_s), 32'(CTL_NONE));
        #2;
        rst_n = 1'b1;
        set_lw();
        #1;
        check_eq("post_rst_lw", 32'(ctl_s), 32'(CTL_LW));
        tick();
        check_eq("post_rst_sc", 32'(hif.stall_cycles), 32'd1);
        set_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: RAW 5, register-address width; CNTW 16, stall-counter width; TMO 255, memory-wait timeout in cycles (1..2^CNTW-1).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 rs1D, rs2D  in  RAW  source registers of the instruction in decode.
REQ-005 rs1E, rs2E, rdE  in  RAW  sources and destination of the instruction in execute.
REQ-006 loadE  in  1  execute instruction is a load.
REQ-007 pcSrcE  in  1  branch/jump taken, resolved in execute.
REQ-008 rdM, regWriteM  in  RAW, 1  memory-stage destination and write enable.
REQ-009 rdW, regWriteW  in  RAW, 1  writeback-stage destination and write enable.
REQ-010 dmem_req, dmem_ack  in  1, 1  memory-stage data-memory request and its acknowledge.
REQ-011 stallF, stallD, stallE, stallM  out  1 each  hold the PC/F, D, E and M pipeline registers.
REQ-012 flushD, flushE, flushW  out  1 each  clear the D, E and W pipeline registers (bubble).
REQ-013 forwardAE, forwardBE  out  2 each  operand-select for E: 00 register file, 01 W result, 10 M result.
REQ-014 mem_err  out  1  sticky memory-timeout error.
REQ-015 stall_cycles  out  CNTW  saturating count of cycles with stallF=1.

Function
REQ-016 Forwarding SHALL be combinational: forwardAE=10 if regWriteM and rdM!=0 and rdM==rs1E; else 01 if regWriteW and rdW!=0 and rdW==rs1E; else 00; forwardBE SHALL be identical but use rs2E.
REQ-017 lwStall SHALL be loadE and rdE!=0 and (rdE==rs1D or rdE==rs2D).
REQ-018 FSM states SHALL be RUN, MEM_WAIT, ERR; the state and a CNTW-bit wait counter are the only control registers.
REQ-019 RUN, dmem_req=1 and dmem_ack=0: stallF, stallD, stallE, stallM, flushW =1; flushD=flushE=0; pcSrcE and lwStall ignored this cycle; next state MEM_WAIT; wait counter <=1.
REQ-020 RUN, dmem_req=1 and dmem_ack=1 in the same cycle: no memory stall, stay RUN.
REQ-021 RUN, no memory stall and pcSrcE=1: flushD=flushE=1, all stalls 0; pcSrcE SHALL take priority over lwStall.
REQ-022 RUN, no memory stall, pcSrcE=0 and lwStall=1: stallF=stallD=flushE=1; all other control outputs 0.
REQ-023 RUN, none of the above: all stall/flush outputs 0.
REQ-024 MEM_WAIT: stall/flush outputs SHALL be as in REQ-019 every cycle. If dmem_ack=1, next state is RUN and the counter clears. Otherwise, if the counter equals TMO, next state is ERR. Otherwise the counter increments.
REQ-025 The branch and load-use hazards held in E/D during MEM_WAIT SHALL be re-evaluated in the first RUN cycle after the ack.
REQ-026 ERR: stallF, stallD, stallE, stallM, flushW =1 permanently; mem_err=1; the state leaves ERR only on reset.
REQ-027 stall_cycles SHALL increment on every clock edge where stallF=1 and SHALL saturate at 2^CNTW-1 without wrapping.
REQ-028 Stall and flush outputs SHALL be combinational from the state and inputs (Moore state plus Mealy hazard terms), with no added latency.

Reset
REQ-029 rst_n=0 SHALL immediately force state RUN, wait counter 0, mem_err 0 and stall_cycles 0, regardless of clk.
REQ-030 Reset asserted in MEM_WAIT or ERR SHALL abandon the wait. The first cycle after release behaves as RUN.

Verification
REQ-031 loadE=1, rdE=5, rs1D=5, no memory stall -> stallF=stallD=flushE=1 for one cycle; stall_cycles 0->1.
REQ-032 pcSrcE=1 with lwStall=1 in the same cycle -> flushD=flushE=1, stallF=0.
REQ-033 regWriteM=1, rdM=3; regWriteW=1, rdW=3; rs1E=3 -> forwardAE=10. Changing rdM to 0 -> forwardAE=01.
REQ-034 dmem_req=1 held, dmem_ack arriving on the 4th cycle -> cycles 1-4 stall all stages with flushW=1; RUN on cycle 5; stall_cycles +4.
REQ-035 TMO=3, dmem_req=1, no ack -> ERR entered after the counter reaches 3; mem_err=1 stays set; rst_n pulse -> mem_err=0, state RUN.
REQ-036 CNTW=4, stall held 20 cycles -> stall_cycles saturates at 15.
